// File: rtl/plot_fb_writer_pkg.sv
// Shared types and defaults for the pixel-plot framebuffer writer.
// Holds the screen geometry defaults, address width and the FIFO entry layout.
package fb_pkg;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;
  localparam int FB_ADDR_W        = 15;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [2:0]           colour;
  } fb_entry_t;

  // Row-major linearisation; 15 bits holds every legal coordinate of a 160x120 screen.
  function automatic logic [FB_ADDR_W-1:0] fb_linear_addr(
    input logic [7:0]           x,
    input logic [6:0]           y,
    input logic [FB_ADDR_W-1:0] width
  );
    return FB_ADDR_W'(y) * width + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead synchronous FIFO with extended (wrap-bit) pointers.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define validity,
  // which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/plot_fb_writer.sv
// Buffers drawing-engine plots into the framebuffer write port, dropping off-screen pixels.
// Define PLOT_FB_STATS_EN to add saturating wr_count/drop_count outputs.
module plot_fb_writer
  import fb_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           vga_x,
  input  logic [6:0]           vga_y,
  input  logic [2:0]           vga_colour,
  input  logic                 vga_plot,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [2:0]           fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready,
  output logic                 empty,
  output logic                 overflow,
  input  logic                 clr_overflow
`ifdef PLOT_FB_STATS_EN
  ,
  output logic [15:0]          wr_count,
  output logic [15:0]          drop_count
`endif
);

  localparam logic [8:0]           X_LIM = 9'(SCREEN_W);
  localparam logic [7:0]           Y_LIM = 8'(SCREEN_H);
  localparam logic [FB_ADDR_W-1:0] W_ADDR = FB_ADDR_W'(SCREEN_W);

  logic      on_screen;
  logic      push;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic      drop_full;
  fb_entry_t in_entry;
  fb_entry_t head;

  assign on_screen = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
  assign push      = vga_plot && on_screen;
  assign pop       = fb_we && fb_ready;
  // A full FIFO still takes the pixel when the head leaves in the same cycle.
  assign drop_full = push && fifo_full && !pop;

  assign in_entry.addr   = fb_linear_addr(vga_x, vga_y, W_ADDR);
  assign in_entry.colour = vga_colour;

  sync_fifo #(
    .WIDTH($bits(fb_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (in_entry),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign fb_we   = !fifo_empty;
  assign empty   = fifo_empty;
  assign fb_addr = head.addr;
  assign fb_data = head.colour;

  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (drop_full)    overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef PLOT_FB_STATS_EN
  logic drop_any;
  assign drop_any = (vga_plot && !on_screen) || drop_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      if (pop && wr_count != 16'hFFFF)        wr_count   <= wr_count + 16'd1;
      if (drop_any && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_plot_fb_writer.sv
// Directed self-checking bench for plot_fb_writer (DEPTH=16, 160x120).
// Writes are captured at the falling edge, when fb_we && fb_ready means a write at the next rise.
module tb_plot_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [2:0]  vga_colour = '0;
  logic        vga_plot = 1'b0;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready = 1'b0;
  logic        empty;
  logic        overflow;
  logic        clr_overflow = 1'b0;
`ifdef PLOT_FB_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] wr_q [$];

  always #5 clk = ~clk;

  plot_fb_writer #(.DEPTH(16), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .fb_ready    (fb_ready),
    .empty       (empty),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
`ifdef PLOT_FB_STATS_EN
    ,
    .wr_count    (wr_count),
    .drop_count  (drop_count)
`endif
  );

  always @(negedge clk) begin
    if (!rst && fb_we && fb_ready) wr_q.push_back({fb_data, fb_addr});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
    step();
    vga_plot   = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    fb_ready = 1'b1;
    while (!empty && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(empty), 32'd1);
  endtask

  initial begin
    int bad;
    int base;

    // Reset state
    step();
    step();
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
`ifdef PLOT_FB_STATS_EN
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
`endif

    // Single pixel: one-cycle latency, 2*160+5 = 325
    fb_ready = 1'b1;
    plot(5, 2, 3'b101);
    check("single_we", 32'(fb_we), 32'd1);
    check("single_addr", 32'(fb_addr), 32'd325);
    check("single_data", 32'(fb_data), 32'd5);
    step();
    check("single_empty", 32'(empty), 32'd1);
    check("single_we_low", 32'(fb_we), 32'd0);
    check("single_nwr", 32'(wr_q.size()), 32'd1);

    // Off-screen pixels are discarded without overflow
    plot(160, 0, 1);
    plot(0, 120, 2);
    check("offscr_we", 32'(fb_we), 32'd0);
    check("offscr_empty", 32'(empty), 32'd1);
    check("offscr_overflow", 32'(overflow), 32'd0);
`ifdef PLOT_FB_STATS_EN
    check("offscr_drop_count", 32'(drop_count), 32'd2);
`endif

    // 17 pushes into a stalled 16-deep FIFO
    wr_q.delete();
    fb_ready = 1'b0;
    for (int i = 0; i < 17; i++) plot(i, 10, i);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_we", 32'(fb_we), 32'd1);
    drain("ovf", 40);
    check("ovf_nwr", 32'(wr_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      check($sformatf("ovf_addr%0d", i), 32'(wr_q[i][14:0]), 32'(1600 + i));
      check($sformatf("ovf_data%0d", i), 32'(wr_q[i][17:15]), 32'(i % 8));
    end
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
`ifdef PLOT_FB_STATS_EN
    check("ovf_wr_count", 32'(wr_count), 32'd17);
    check("ovf_drop_count", 32'(drop_count), 32'd3);
`endif

    // Full FIFO with simultaneous push and pop
    wr_q.delete();
    fb_ready = 1'b0;
    for (int i = 0; i < 16; i++) plot(i, 20, 7);
    check("full_no_ovf", 32'(overflow), 32'd0);
    fb_ready = 1'b1;
    plot(100, 20, 4);
    fb_ready = 1'b0;
    check("pushpop_no_ovf", 32'(overflow), 32'd0);
    check("pushpop_one_wr", 32'(wr_q.size()), 32'd1);
    drain("pushpop", 40);
    check("pushpop_occupancy", 32'(wr_q.size() - 1), 32'd16);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i][14:0] != 15'((i < 16) ? 3200 + i : 3300)) bad++;
    check("pushpop_order", 32'(bad), 32'd0);

    // Gap-free stream against a 50% drain must overflow, landing writes stay ordered
    wr_q.delete();
    fb_ready = 1'b0;
    vga_plot = 1'b1;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(x + y);
        fb_ready   = ~fb_ready;
        step();
      end
    end
    vga_plot = 1'b0;
    drain("streamA", 40);
    check("streamA_overflow", 32'(overflow), 32'd1);
    check("streamA_some_lost", 32'(wr_q.size() < 19200), 32'd1);
    check("streamA_first", 32'(wr_q.size() > 0 ? wr_q[0][14:0] : 15'h7FFF), 32'd0);
    bad = 0;
    for (int i = 1; i < wr_q.size(); i++)
      if (wr_q[i][14:0] <= wr_q[i-1][14:0]) bad++;
    check("streamA_monotonic", 32'(bad), 32'd0);

    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;

    // Stream with an idle cycle between pixels: every address lands once, in order
    wr_q.delete();
    fb_ready = 1'b0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(x + y);
        vga_plot   = 1'b1;
        fb_ready   = ~fb_ready;
        step();
        vga_plot   = 1'b0;
        fb_ready   = ~fb_ready;
        step();
      end
    end
    drain("streamB", 40);
    check("streamB_overflow", 32'(overflow), 32'd0);
    check("streamB_nwr", 32'(wr_q.size()), 32'd19200);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      base = (i % 160) + (i / 160);
      if (wr_q[i][14:0] != 15'(i) || wr_q[i][17:15] != 3'(base)) bad++;
    end
    check("streamB_order", 32'(bad), 32'd0);

    // Reset with 8 entries queued
    fb_ready = 1'b0;
    for (int i = 0; i < 8; i++) plot(i, 50, 3);
    check("midrst_pre_we", 32'(fb_we), 32'd1);
    rst = 1'b1;
    step();
    check("midrst_we", 32'(fb_we), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
`ifdef PLOT_FB_STATS_EN
    check("midrst_wr_count", 32'(wr_count), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
`endif
    rst = 1'b0;
    wr_q.delete();
    fb_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("midrst_no_stale", 32'(wr_q.size()), 32'd0);
    check("midrst_still_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/plot_fb_writer.md
# plot_fb_writer

Buffers the pixel-plot stream produced by the shape-drawing engines (clear, circle, Reuleaux) and drains it into the 160×120, 3-bit-per-pixel framebuffer write port. The framebuffer port can stall (e.g. during scanout arbitration), but the drawing engines cannot: they have no backpressure. This block therefore absorbs bursts in a small FIFO, linearises (x, y) into a framebuffer address, discards off-screen pixels, and flags any pixel lost to overflow. It sits between the drawing engines' `vga_*` outputs and the framebuffer memory.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥ 2.
- `SCREEN_W`, default 160: visible width in pixels.
- `SCREEN_H`, default 120: visible height in pixels.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `vga_x`  in  8: pixel x from the drawing engine.
- `vga_y`  in  7: pixel y from the drawing engine.
- `vga_colour`  in  3: pixel colour.
- `vga_plot`  in  1: pixel valid; sampled every cycle, no ready is returned.
- `fb_addr`  out  15: framebuffer address, `y*SCREEN_W + x`.
- `fb_data`  out  3: colour to write.
- `fb_we`  out  1: write request; high exactly when the FIFO is non-empty.
- `fb_ready`  in  1: the framebuffer accepts the write when `fb_we && fb_ready`.
- `empty`  out  1: FIFO empty; upstream uses it to confirm that a drawing has fully landed.
- `overflow`  out  1: sticky flag; set when a valid on-screen pixel was dropped because the FIFO was full.
- `clr_overflow`  in  1: clears `overflow`.

## Operation
- Push condition: `vga_plot==1`, `vga_x < SCREEN_W` and `vga_y < SCREEN_H`.
  - The address is computed at push time (15-bit unsigned, no truncation for legal coordinates).
  - The entry {addr, colour} is stored.
- Off-screen pixels are silently discarded. They never set `overflow`.
- Pop condition: `fb_we && fb_ready`. The head advances one entry.
- Head presentation is show-ahead: `fb_addr`/`fb_data` reflect the head entry whenever `fb_we==1`. They hold stable until popped. When `fb_we==0` they are don't-care.
- Pointers are `log2(DEPTH)+1` bits wide and wrap modulo `2*DEPTH`.
  - Full: the MSBs differ and the LSBs are equal.
  - Empty: the pointers are equal.
- Full with push and pop in the same cycle: the push is accepted, the occupancy stays at `DEPTH`, and `overflow` is not set.
- Full with push and no pop: the pixel is dropped and `overflow` is set.
- Empty with push and `fb_ready`: no pop occurs that cycle. The pixel appears at the head on the next cycle. There is no same-cycle bypass.
- If `overflow` is set and `clr_overflow` is asserted in the same cycle, set wins.
- Order is strictly preserved: writes leave in push order.

## Timing
- Reset values: `fb_we=0`, `empty=1`, `overflow=0`, both pointers 0, stats counters 0. `fb_addr`/`fb_data` are don't-care while `fb_we=0`.
- Reset mid-operation: the FIFO contents are abandoned and `fb_we` falls in the cycle after the reset edge.
- Latency: a pixel pushed at edge N into an empty FIFO gives `fb_we=1` during cycle N+1, and is written at edge N+1 if `fb_ready=1`.
- Throughput: 1 pixel/cycle sustained when `fb_ready` is held high.
- `empty` and `fb_we` are derived directly from the pointers and change only on clock edges.

## Configuration
- `PLOT_FB_STATS_EN` defined: adds output `wr_count` [15:0], incremented on each accepted framebuffer write, and output `drop_count` [15:0], incremented on each off-screen or overflow drop. Both counters saturate at 16'hFFFF and clear on `rst`.
- `PLOT_FB_STATS_EN` undefined: neither port nor the counters exist. Everything else is unchanged.

## Structure
- Package `fb_pkg` holds:
  - `SCREEN_W`/`SCREEN_H` defaults.
  - `FB_ADDR_W = 15`.
  - The typedef `fb_entry_t` = struct {`logic [14:0] addr`; `logic [2:0] colour`}.
- Sub-module `sync_fifo`: a generic width/depth FIFO with push/pop/full/empty. It contains no drop or overflow policy.
- The top level holds:
  - The range check.
  - Address computation.
  - Overflow flag.
  - Optional stats.

## Test plan
- Reset, then push (x=5, y=2, colour=3'b101) with `fb_ready=1` → `fb_we=1` one cycle later with `fb_addr=325`, `fb_data=5`; then `empty=1`.
- Push (160, 0) and (0, 120) → no `fb_we`, `overflow=0`. With stats enabled, `drop_count=2`.
- Hold `fb_ready=0` and push 17 on-screen pixels with `DEPTH=16` → the 17th is dropped and `overflow=1`. Then raise `fb_ready` → exactly 16 writes in push order and `empty=1`. Pulse `clr_overflow` → `overflow=0`.
- FIFO full, then push and `fb_ready=1` in the same cycle → occupancy stays 16 and `overflow` stays 0.
- Stream (0,0) through (159,119) continuously with `fb_ready` toggling every other cycle (DEPTH=16). A plot stream with no gaps outruns a 50% drain, so the FIFO fills and then overflows; the bench asserts `overflow=1` and checks that the writes that do land are in increasing address order with no duplicates. A separate pass inserts one idle cycle between pixels, so that the drain rate matches the push rate, and requires all 19200 addresses 0…19199 written exactly once in order with `overflow=0`.
- Assert `rst` while 8 entries are queued → `fb_we=0` on the next cycle. After release, no stale writes appear.
